// File: rtl/clk_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_meter_pkg
// Brief   : Shared state encoding and default sizing for clk_period_meter.
// Revision: 1.0 - initial release
// ============================================================================
package clk_meter_pkg;

    localparam int          DEF_CNT_W          = 32;
    localparam int          DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 300_000_000;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t MEASURE = 2'd1;
    localparam state_t LOST    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge_detect
// Brief   : Multi-flop synchroniser with a registered rising-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstN,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_syncd_q;
    logic                   r_rise;
    logic                   w_syncd;

    assign w_syncd = r_sync[SYNC_STAGES-1];

    // r_sync[0] is the only flop that may go metastable.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_sync    <= '0;
            r_syncd_q <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_syncd_q <= w_syncd;
            r_rise    <= w_syncd & ~r_syncd_q;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module  : clk_period_meter
// Brief   : Measures the period of a slow asynchronous input in inCLK cycles.
// Revision: 1.0 - initial release
// ============================================================================
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int          CNT_W          = DEF_CNT_W,
    parameter int          SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             inCLK,
    input  logic             rstN,
    input  logic             slowIn,
    output logic             edgeTick,
    output logic [CNT_W-1:0] period,
    output logic             periodValid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             w_rise;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_edgeTick;
    logic             r_periodValid;
    logic             r_locked;
    logic             r_timeout;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (inCLK),
        .i_rstN  (rstN),
        .i_async (slowIn),
        .o_rise  (w_rise)
    );

    always_ff @(posedge inCLK) begin
        if (!rstN) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_period      <= '0;
            r_edgeTick    <= 1'b0;
            r_periodValid <= 1'b0;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_edgeTick    <= w_rise;
            r_periodValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the last count wins over the timeout.
                    if (w_rise) begin
                        r_period      <= r_cnt + 1'b1;
                        r_periodValid <= 1'b1;
                        r_locked      <= 1'b1;
                        r_cnt         <= '0;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_state   <= LOST;
                        r_timeout <= 1'b1;
                        r_locked  <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LOST: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state   <= MEASURE;
                        r_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign edgeTick    = r_edgeTick;
    assign period      = r_period;
    assign periodValid = r_periodValid;
    assign locked      = r_locked;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_period_meter
// Brief   : Scoreboard bench for clk_period_meter (TIMEOUT_CYCLES=100).
// Revision: 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    localparam int c_CNT_W = 32;

    logic               inCLK = 1'b0;
    logic               rstN;
    logic               slowIn;
    logic               edgeTick;
    logic [c_CNT_W-1:0] period;
    logic               periodValid;
    logic               locked;
    logic               timeout;

    clk_period_meter #(
        .CNT_W          (c_CNT_W),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .inCLK       (inCLK),
        .rstN        (rstN),
        .slowIn      (slowIn),
        .edgeTick    (edgeTick),
        .period      (period),
        .periodValid (periodValid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 inCLK = ~inCLK;

    typedef struct {
        int          cyc;
        bit          tick;
        bit          valid;
        logic [31:0] per;
        bit          lck;
        bit          tmo;
    } ev_t;

    ev_t q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  last_tick;
    logic prev_tmo = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input bit tk, input bit v, input int p, input bit l, input bit t);
        ev_t e;
        e.cyc = c; e.tick = tk; e.valid = v; e.per = p; e.lck = l; e.tmo = t;
        q.push_back(e);
    endtask

    // A rise driven before posedge P reaches the outputs after posedge P+3.
    task automatic pulse(input int hi, input int lo, input bit ev, input int ep, input bit el);
        @(negedge inCLK);
        slowIn = 1'b1;
        push(cyc + 4, 1'b1, ev, ep, el, 1'b0);
        last_tick = cyc + 4;
        repeat (hi - 1) @(negedge inCLK) slowIn = 1'b1;
        repeat (lo) @(negedge inCLK) slowIn = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_edgeTick", {31'd0, edgeTick}, 0);
        chk("rst_periodValid", {31'd0, periodValid}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        chk("rst_period", period, 0);
    endtask

    // Monitor: any tick, valid pulse or timeout edge must match the queue head.
    always @(posedge inCLK) begin
        ev_t e;
        cyc = cyc + 1;
        #1;
        if (edgeTick === 1'b1 || periodValid === 1'b1 || timeout !== prev_tmo) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got tick=%0b valid=%0b timeout=%0b expected none (cycle %0d)",
                         edgeTick, periodValid, timeout, cyc);
            end else begin
                e = q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_edgeTick", {31'd0, edgeTick}, {31'd0, e.tick});
                chk("ev_periodValid", {31'd0, periodValid}, {31'd0, e.valid});
                chk("ev_period", period, e.per);
                chk("ev_locked", {31'd0, locked}, {31'd0, e.lck});
                chk("ev_timeout", {31'd0, timeout}, {31'd0, e.tmo});
            end
        end
        prev_tmo = timeout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        rstN   = 1'b0;
        slowIn = 1'b0;

        // 1. Reset held with slowIn toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge inCLK);
            slowIn = (i % 2 == 0);
            @(posedge inCLK);
            #1;
            check_reset_outputs();
        end
        @(negedge inCLK);
        rstN   = 1'b1;
        slowIn = 1'b0;
        repeat (3) @(negedge inCLK) slowIn = 1'b0;

        // 2. 5/5 square wave: first rise only arms, later rises measure 10
        pulse(5, 5, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) pulse(5, 5, 1'b1, 10, 1'b1);

        // 3. Input lost: timeout exactly 100 cycles after the last tick
        push(last_tick + 100, 1'b0, 1'b0, 10, 1'b0, 1'b1);
        repeat (110) @(negedge inCLK) slowIn = 1'b0;

        // 4. Restart from LOST, then a 20-cycle period
        pulse(5, 15, 1'b0, 10, 1'b0);
        pulse(5, 95, 1'b1, 20, 1'b1);

        // 5. Rise on the last count before timeout: period 100, no LOST
        pulse(5, 5, 1'b1, 100, 1'b1);

        // 6. Reset mid-MEASURE with slowIn high
        @(negedge inCLK);
        slowIn = 1'b1;
        push(cyc + 4, 1'b1, 1'b1, 10, 1'b1, 1'b0);
        repeat (7) @(negedge inCLK) slowIn = 1'b1;
        @(negedge inCLK);
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge inCLK);
            #1;
            check_reset_outputs();
        end
        @(negedge inCLK);
        rstN = 1'b1;
        push(cyc + 4, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge inCLK) slowIn = 1'b1;
        repeat (5) @(negedge inCLK) slowIn = 1'b0;
        // Confirms MEASURE was entered: the next rise is a real measurement
        pulse(5, 5, 1'b1, 10, 1'b1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge inCLK);
        repeat (2) @(posedge inCLK);
        #2;
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
